// File: rtl/fpu_man_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpu_man_round_pipe
// Purpose  : Two-stage pipelined mantissa rounding unit for the FPU add/sub
//            datapath. Sits after the normaliser. It rounds the kept mantissa
//            field using the L/G/R/S bits and propagates any mantissa carry-out
//            into the exponent.
//            Stage 1 registers the kept field, the exponent, the inexact flag
//            and the increment decision. Stage 2 applies the increment and
//            registers the final result and flags.
//            Valid/ready handshaking on both sides gives full throughput with
//            back-pressure.
// Config   : FPU_ROUND_RMODE_EN
//              defined   - i_rmode selects RNE/RTZ/RDN/RUP.
//              undefined - rounding is fixed to RNE; i_rmode and i_sign are
//                          ignored. The port list is unchanged.
// Ports    : i_clk, i_rst_n      clock and asynchronous active-low reset
//            i_valid / o_ready   input handshake
//            i_man, i_exp        normalised mantissa and its biased exponent
//            i_sign, i_rmode     result sign and rounding mode
//                                (00 RNE, 01 RTZ, 10 RDN, 11 RUP)
//            o_valid / i_ready   output handshake
//            o_man_result        rounded mantissa (hidden bit excluded)
//            o_exp               exponent, incremented on mantissa carry-out
//            o_ov_flow           mantissa carry-out occurred
//            o_exp_ov            incremented exponent reached all-ones
//            o_inexact           any of G/R/S was set
// Revision : 1.0 - initial release
// ============================================================================
module fpu_man_round_pipe #(
    parameter int SIZE_MAN        = 32,
    parameter int SIZE_MAN_RESULT = 23,
    parameter int SIZE_EXP        = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [SIZE_MAN-1:0]        i_man,
    input  logic [SIZE_EXP-1:0]        i_exp,
    input  logic                       i_sign,
    input  logic [1:0]                 i_rmode,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [SIZE_MAN_RESULT-1:0] o_man_result,
    output logic [SIZE_EXP-1:0]        o_exp,
    output logic                       o_ov_flow,
    output logic                       o_exp_ov,
    output logic                       o_inexact
);

    // Bit index of L, the least significant kept bit.
    localparam int c_LPOS = SIZE_MAN - SIZE_MAN_RESULT;

`ifdef FPU_ROUND_RMODE_EN
    localparam logic [1:0] c_RM_RNE = 2'b00;
    localparam logic [1:0] c_RM_RTZ = 2'b01;
    localparam logic [1:0] c_RM_RDN = 2'b10;
    localparam logic [1:0] c_RM_RUP = 2'b11;
`endif

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_adv1;
    logic w_adv2;

    // A stage may advance when it is empty or when the stage after it
    // is advancing; this lets accept and deliver occur in the same cycle.
    assign w_adv2  = ~r_s2_valid | i_ready;
    assign w_adv1  = ~r_s1_valid | w_adv2;
    assign o_ready = w_adv1;
    assign o_valid = r_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1 combinational: L/G/R/S extraction and increment decision
    // ------------------------------------------------------------------
    logic w_lsb;
    logic w_guard;
    logic w_round;
    logic w_sticky;
    logic w_inexact;
    logic w_inc_rne;
    logic w_inc;

    assign w_lsb     = i_man[c_LPOS];
    assign w_guard   = i_man[c_LPOS-1];
    assign w_round   = i_man[c_LPOS-2];
    assign w_sticky  = |i_man[c_LPOS-3:0];
    assign w_inexact = w_guard | w_round | w_sticky;

    // Round-to-nearest-even: round up above the halfway point, and on an
    // exact tie only when the kept field is odd.
    assign w_inc_rne = w_guard & (w_round | w_sticky | w_lsb);

`ifdef FPU_ROUND_RMODE_EN
    always_comb begin
        w_inc = 1'b0;
        case (i_rmode)
            c_RM_RNE: w_inc = w_inc_rne;
            c_RM_RTZ: w_inc = 1'b0;
            // Directed modes round away from zero only toward their own
            // infinity, so the sign decides whether the magnitude grows.
            c_RM_RDN: w_inc = i_sign & w_inexact;
            c_RM_RUP: w_inc = ~i_sign & w_inexact;
            default:  w_inc = 1'b0;
        endcase
    end
`else
    assign w_inc = w_inc_rne;

    // Mode and sign only matter for the directed modes.
    logic w_unused_mode;
    assign w_unused_mode = ^{i_rmode, i_sign};
`endif

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] r_s1_man;
    logic [SIZE_EXP-1:0]        r_s1_exp;
    logic                       r_s1_inc;
    logic                       r_s1_inexact;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_man     <= '0;
            r_s1_exp     <= '0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
        end else if (w_adv1) begin
            r_s1_valid <= i_valid;
            // Data only moves with a real beat so idle cycles leave the
            // registers untouched.
            if (i_valid) begin
                r_s1_man     <= i_man[SIZE_MAN-1 -: SIZE_MAN_RESULT];
                r_s1_exp     <= i_exp;
                r_s1_inc     <= w_inc;
                r_s1_inexact <= w_inexact;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: apply increment, detect carry-out
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT:0]   w_sum;
    logic                       w_carry;
    logic [SIZE_EXP-1:0]        w_exp_inc;
    logic [SIZE_MAN_RESULT-1:0] w_man_next;
    logic [SIZE_EXP-1:0]        w_exp_next;
    logic                       w_exp_ov_next;

    assign w_sum     = {1'b0, r_s1_man} + {{SIZE_MAN_RESULT{1'b0}}, r_s1_inc};
    assign w_carry   = w_sum[SIZE_MAN_RESULT];
    assign w_exp_inc = r_s1_exp + {{(SIZE_EXP-1){1'b0}}, 1'b1};

    // On carry-out the mantissa becomes 1.000... with the hidden bit moved
    // into the exponent, so the stored fraction is zero.
    assign w_man_next    = w_carry ? '0 : w_sum[SIZE_MAN_RESULT-1:0];
    assign w_exp_next    = w_carry ? w_exp_inc : r_s1_exp;
    assign w_exp_ov_next = w_carry & (&w_exp_inc);

    // ------------------------------------------------------------------
    // Stage 2 registers (drive the outputs directly)
    // ------------------------------------------------------------------
    logic [SIZE_MAN_RESULT-1:0] r_s2_man;
    logic [SIZE_EXP-1:0]        r_s2_exp;
    logic                       r_s2_ov_flow;
    logic                       r_s2_exp_ov;
    logic                       r_s2_inexact;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s2_valid   <= 1'b0;
            r_s2_man     <= '0;
            r_s2_exp     <= '0;
            r_s2_ov_flow <= 1'b0;
            r_s2_exp_ov  <= 1'b0;
            r_s2_inexact <= 1'b0;
        end else if (w_adv2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_man     <= w_man_next;
                r_s2_exp     <= w_exp_next;
                r_s2_ov_flow <= w_carry;
                r_s2_exp_ov  <= w_exp_ov_next;
                r_s2_inexact <= r_s1_inexact;
            end
        end
    end

    assign o_man_result = r_s2_man;
    assign o_exp        = r_s2_exp;
    assign o_ov_flow    = r_s2_ov_flow;
    assign o_exp_ov     = r_s2_exp_ov;
    assign o_inexact    = r_s2_inexact;

endmodule
`default_nettype wire

// File: tb/tb_fpu_man_round_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpu_man_round_pipe
// Purpose  : Self-checking bench for fpu_man_round_pipe with default
//            parameters. Directed cases carry hand-derived expected results;
//            random traffic is scored against an arithmetic rounding model.
//            Honors FPU_ROUND_RMODE_EN the same way the design does.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_man_round_pipe;

    localparam int c_MAN  = 32;
    localparam int c_RES  = 23;
    localparam int c_EXP  = 8;
    localparam int c_LPOS = c_MAN - c_RES;

    logic             clk;
    logic             rst_n;
    logic             valid_in;
    logic             ready_out;
    logic [c_MAN-1:0] man_in;
    logic [c_EXP-1:0] exp_in;
    logic             sign_in;
    logic [1:0]       rmode_in;
    logic             valid_out;
    logic             ready_in;
    logic [c_RES-1:0] man_out;
    logic [c_EXP-1:0] exp_out;
    logic             ov_flow;
    logic             exp_ov;
    logic             inexact;

    fpu_man_round_pipe #(
        .SIZE_MAN        (c_MAN),
        .SIZE_MAN_RESULT (c_RES),
        .SIZE_EXP        (c_EXP)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (valid_in),
        .o_ready      (ready_out),
        .i_man        (man_in),
        .i_exp        (exp_in),
        .i_sign       (sign_in),
        .i_rmode      (rmode_in),
        .o_valid      (valid_out),
        .i_ready      (ready_in),
        .o_man_result (man_out),
        .o_exp        (exp_out),
        .o_ov_flow    (ov_flow),
        .o_exp_ov     (exp_ov),
        .o_inexact    (inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [c_RES-1:0] man;
        logic [c_EXP-1:0] exp;
        logic             ov;
        logic             eov;
        logic             inx;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_deliv = 0;
    logic chk_lat = 1'b0;
    logic held_v = 1'b0;
    logic [c_RES+c_EXP+2:0] held_val;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic exp_t mk(input logic [c_RES-1:0] m, input logic [c_EXP-1:0] e,
                                input logic ov, input logic eov, input logic inx);
        exp_t x;
        x.man = m; x.exp = e; x.ov = ov; x.eov = eov; x.inx = inx; x.acc = 0;
        return x;
    endfunction

    // Rounding model: treat the mantissa as an integer quotient/remainder
    // split at the kept-field boundary and round by comparing the remainder
    // to one half unit of the last kept place.
    function automatic exp_t model(input logic [c_MAN-1:0] m, input logic [c_EXP-1:0] e,
                                   input logic s, input logic [1:0] rm);
        longint unsigned kept, rem, half, sum, inc;
        int mode;
        exp_t x;
        kept = longint'(m) / (64'd1 << c_LPOS);
        rem  = longint'(m) % (64'd1 << c_LPOS);
        half = 64'd1 << (c_LPOS - 1);
`ifdef FPU_ROUND_RMODE_EN
        mode = int'(rm);
`else
        mode = 0;
`endif
        case (mode)
            0:       inc = ((rem > half) || (rem == half && (kept % 2) == 1)) ? 1 : 0;
            1:       inc = 0;
            2:       inc = (s && rem != 0) ? 1 : 0;
            default: inc = (!s && rem != 0) ? 1 : 0;
        endcase
        sum = kept + inc;
        x.inx = (rem != 0);
        if (sum == (64'd1 << c_RES)) begin
            x.man = '0;
            x.ov  = 1'b1;
            x.exp = c_EXP'((int'(e) + 1) % 256);
            x.eov = ((int'(e) + 1) % 256) == 255;
        end else begin
            x.man = c_RES'(sum);
            x.ov  = 1'b0;
            x.exp = e;
            x.eov = 1'b0;
        end
        x.acc = 0;
        return x;
    endfunction

    // One clock cycle: drive at the falling edge, sample 1 ns later, and
    // record whatever handshakes the next rising edge will complete.
    task automatic step(input logic v, input logic [c_MAN-1:0] m, input logic [c_EXP-1:0] e,
                        input logic s, input logic [1:0] rm, input logic rdy,
                        input logic use_tab, input exp_t tab, output logic acc);
        exp_t x;
        logic [c_RES+c_EXP+2:0] cur;
        @(negedge clk);
        valid_in = v; man_in = m; exp_in = e; sign_in = s; rmode_in = rm; ready_in = rdy;
        #1;
        cur = {ov_flow, exp_ov, inexact, exp_out, man_out};
        if (held_v) check_val("hold", 64'(cur), 64'(held_val));
        held_v   = valid_out && !rdy;
        held_val = cur;
        acc = v && ready_out;
        if (acc) begin
            x = use_tab ? tab : model(m, e, s, rm);
            x.acc = cyc;
            sb.push_back(x);
        end
        if (valid_out && rdy) begin
            n_deliv++;
            if (sb.size() == 0) begin
                check_val("spurious_beat", 64'(1), 64'(0));
            end else begin
                x = sb.pop_front();
                check_val("man", 64'(man_out), 64'(x.man));
                check_val("exp", 64'(exp_out), 64'(x.exp));
                check_val("flags{ov,eov,inx}", 64'({ov_flow, exp_ov, inexact}),
                          64'({x.ov, x.eov, x.inx}));
                if (chk_lat) check_val("latency", 64'(cyc - x.acc), 64'(2));
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        logic a;
        exp_t d;
        d = mk('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 2'b00, 1'b1, 1'b0, d, a);
    endtask

    typedef struct {
        logic [c_MAN-1:0] m;
        logic [c_EXP-1:0] e;
        logic             s;
        logic [1:0]       rm;
        exp_t             x;
    } vec_t;

    vec_t tab[$];
    logic en;

    initial begin
        logic a;
        vec_t vv;
        exp_t d;
        int   c;
        logic saw_stall;
        logic [c_MAN-1:0] pm;
        logic [c_EXP-1:0] pe;
        logic ps;
        logic [1:0] prm;
        logic pend;

`ifdef FPU_ROUND_RMODE_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        d = mk('0, '0, 1'b0, 1'b0, 1'b0);
        valid_in = 0; man_in = '0; exp_in = '0; sign_in = 0; rmode_in = 0; ready_in = 1;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #3;
        check_val("reset_valid", 64'(valid_out), 64'(0));
        check_val("reset_ready", 64'(ready_out), 64'(1));
        check_val("reset_data", 64'({ov_flow, exp_ov, inexact, exp_out, man_out}), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        tab.push_back('{32'h0000_0180, 8'h10, 1'b0, 2'b00, mk(23'd1, 8'h10, 0, 0, 1)});
        tab.push_back('{32'h0000_0100, 8'h10, 1'b0, 2'b00, mk(23'd0, 8'h10, 0, 0, 1)});
        tab.push_back('{32'h0000_0300, 8'h10, 1'b0, 2'b00, mk(23'd2, 8'h10, 0, 0, 1)});
        tab.push_back('{32'h0000_0100, 8'h22, 1'b0, 2'b11, mk(en ? 23'd1 : 23'd0, 8'h22, 0, 0, 1)});
        tab.push_back('{32'h0000_0100, 8'h22, 1'b1, 2'b11, mk(23'd0, 8'h22, 0, 0, 1)});
        tab.push_back('{32'hFFFF_FF80, 8'h7F, 1'b0, 2'b00, mk(23'd0, 8'h80, 1, 0, 1)});
        tab.push_back('{32'hFFFF_FF80, 8'hFE, 1'b0, 2'b00, mk(23'd0, 8'hFF, 1, 1, 1)});
        tab.push_back('{32'h1234_5600, 8'h40, 1'b0, 2'b00, mk(23'h091A2B, 8'h40, 0, 0, 0)});
        tab.push_back('{32'h1234_5600, 8'h40, 1'b1, 2'b10, mk(23'h091A2B, 8'h40, 0, 0, 0)});
        tab.push_back('{32'h0000_01FF, 8'h05, 1'b0, 2'b01, mk(en ? 23'd0 : 23'd1, 8'h05, 0, 0, 1)});
        tab.push_back('{32'h0000_0080, 8'h05, 1'b1, 2'b10, mk(en ? 23'd1 : 23'd0, 8'h05, 0, 0, 1)});

        chk_lat = 1'b1;
        foreach (tab[i]) begin
            vv = tab[i];
            step(1'b1, vv.m, vv.e, vv.s, vv.rm, 1'b1, 1'b1, vv.x, a);
            check_val("dir_accept", 64'(a), 64'(1));
            idle(3);
        end
        // Back-to-back directed beats for full throughput.
        foreach (tab[i]) begin
            vv = tab[i];
            step(1'b1, vv.m, vv.e, vv.s, vv.rm, 1'b1, 1'b1, vv.x, a);
        end
        idle(3);
        chk_lat = 1'b0;
        check_val("dir_drained", 64'(sb.size()), 64'(0));

        // Back-pressure: 8 beats, downstream stalled on cycles 3..6.
        n_deliv = 0;
        saw_stall = 1'b0;
        c = 0;
        pend = 1'b0;
        pm = '0; pe = '0; ps = 0; prm = 0;
        begin : bp
            int sent;
            sent = 0;
            while ((n_deliv < 8) && (c < 60)) begin
                if (!pend && sent < 8) begin
                    pm = $urandom; pe = 8'($urandom); ps = 1'($urandom); prm = 2'($urandom);
                    pend = 1'b1;
                end
                step(pend, pm, pe, ps, prm, !(c >= 3 && c <= 6), 1'b0, d, a);
                if (pend && !ready_out) saw_stall = 1'b1;
                if (a) begin pend = 1'b0; sent++; end
                c++;
            end
        end
        check_val("bp_ready_dropped", 64'(saw_stall), 64'(1));
        check_val("bp_delivered", 64'(n_deliv), 64'(8));
        check_val("bp_drained", 64'(sb.size()), 64'(0));

        // Random traffic with random valid/ready; pending beat is held until taken.
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 9) < 7)) begin
                pm = $urandom;
                case ($urandom_range(0, 5))
                    0: pm[c_LPOS-1:0] = 9'h100;
                    1: pm[c_MAN-1:c_LPOS-1] = '1;
                    2: pm[c_LPOS-1:0] = '0;
                    default: ;
                endcase
                pe  = ($urandom_range(0, 3) == 0) ? 8'hFE : 8'($urandom);
                ps  = 1'($urandom);
                prm = 2'($urandom);
                pend = 1'b1;
            end
            step(pend, pm, pe, ps, prm, ($urandom_range(0, 9) < 7), 1'b0, d, a);
            if (a) pend = 1'b0;
        end
        while (pend && cyc < 5000) begin
            step(1'b1, pm, pe, ps, prm, 1'b1, 1'b0, d, a);
            if (a) pend = 1'b0;
        end
        idle(4);
        check_val("rand_drained", 64'(sb.size()), 64'(0));

        // Reset with both stages full and downstream stalled.
        d = mk('0, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 32'h0000_0180 + i * 32'h200, 8'h11, 1'b0, 2'b00, 1'b0, 1'b0, d, a);
        check_val("pre_reset_valid", 64'(valid_out), 64'(1));
        check_val("pre_reset_ready", 64'(ready_out), 64'(0));
        #2 rst_n = 1'b0;
        #1;
        check_val("mid_reset_valid", 64'(valid_out), 64'(0));
        check_val("mid_reset_data", 64'({ov_flow, exp_ov, inexact, exp_out, man_out}), 64'(0));
        check_val("mid_reset_ready", 64'(ready_out), 64'(1));
        sb.delete();
        held_v = 1'b0;
        valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(5);
        step(1'b1, 32'h0000_0300, 8'h33, 1'b0, 2'b00, 1'b1, 1'b1, mk(23'd2, 8'h33, 0, 0, 1), a);
        idle(4);
        check_val("post_reset_drained", 64'(sb.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
